// File: rtl/lsu_mem_wb_stage_pkg.sv
// Shared definitions for the memory/writeback stage: opcodes, funct3 codes,
// access-size decoding and byte-lane mask helpers.
package lsu_mem_wb_stage_pkg;

  localparam int OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BMASK_BYTE = 4'b0001;
  localparam logic [3:0] BMASK_HALF = 4'b0011;
  localparam logic [3:0] BMASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Reserved funct3 encodings fall through to a full-word access.
  function automatic acc_size_e decode_size(input logic [2:0] f3, input logic is_load);
    if (f3 == F3_LB || (is_load && f3 == F3_LBU)) return SZ_BYTE;
    if (f3 == F3_LH || (is_load && f3 == F3_LHU)) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
    return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
  endfunction

  function automatic logic [3:0] byte_mask(input acc_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return BMASK_BYTE << off;
      SZ_HALF: return BMASK_HALF << off;
      default: return BMASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_wb_stage_if.sv
// Execute-side request and writeback-side response bundle of the memory/writeback stage.
interface lsu_mem_wb_stage_if #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3
) ();

  logic                                           ls_i_valid;
  logic [lsu_mem_wb_stage_pkg::OPCODE_WIDTH-1:0]  ls_i_opcode;
  logic [FUNCT_WIDTH-1:0]                         ls_i_funct3;
  logic [DWIDTH-1:0]                              ls_i_alu_value;
  logic [DWIDTH-1:0]                              ls_i_rs2_data;
  logic [AWIDTH-1:0]                              ls_i_rd_addr;
  logic                                           ls_i_rd_we;
  logic                                           ls_i_stall;
  logic                                           ls_i_flush;
  logic                                           ls_o_stall;
  logic                                           ls_o_valid;
  logic [AWIDTH-1:0]                              ls_o_rd_addr;
  logic [DWIDTH-1:0]                              ls_o_rd_data;
  logic                                           ls_o_rd_we;
  logic                                           ls_o_misaligned;
  logic                                           ls_o_sb_empty;

  modport master (
    output ls_i_valid, ls_i_opcode, ls_i_funct3, ls_i_alu_value, ls_i_rs2_data,
           ls_i_rd_addr, ls_i_rd_we, ls_i_stall, ls_i_flush,
    input  ls_o_stall, ls_o_valid, ls_o_rd_addr, ls_o_rd_data, ls_o_rd_we,
           ls_o_misaligned, ls_o_sb_empty
  );

  modport slave (
    input  ls_i_valid, ls_i_opcode, ls_i_funct3, ls_i_alu_value, ls_i_rs2_data,
           ls_i_rd_addr, ls_i_rd_we, ls_i_stall, ls_i_flush,
    output ls_o_stall, ls_o_valid, ls_o_rd_addr, ls_o_rd_data, ls_o_rd_we,
           ls_o_misaligned, ls_o_sb_empty
  );

endinterface

// File: rtl/lsu_store_buffer.sv
// Circular store FIFO with a parallel word-address match used to hold back
// loads that would otherwise read stale memory.
module lsu_store_buffer #(
  parameter int SB_DEPTH = 4,
  parameter int WAW      = 30,
  parameter int DWIDTH   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_i,
  input  logic [WAW-1:0]    enq_waddr_i,
  input  logic [DWIDTH-1:0] enq_data_i,
  input  logic [3:0]        enq_mask_i,
  input  logic              deq_i,
  input  logic [WAW-1:0]    lookup_waddr_i,
  output logic              hit_o,
  output logic              empty_o,
  output logic [WAW-1:0]    head_waddr_o,
  output logic [DWIDTH-1:0] head_data_o,
  output logic [3:0]        head_mask_o
);

  localparam int PW = $clog2(SB_DEPTH);

  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PW:0]         count_q, count_d;
  logic [SB_DEPTH-1:0] vld_q, vld_d;
  logic [WAW-1:0]      waddr_q [SB_DEPTH];
  logic [DWIDTH-1:0]   data_q  [SB_DEPTH];
  logic [3:0]          mask_q  [SB_DEPTH];

  // Dequeue is applied before enqueue so a full buffer refilling the
  // slot it just freed keeps that slot valid.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    count_d = count_q + (PW+1)'(enq_i) - (PW+1)'(deq_i);
    if (deq_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (enq_i) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_i) begin
      waddr_q[tail_q] <= enq_waddr_i;
      data_q[tail_q]  <= enq_data_i;
      mask_q[tail_q]  <= enq_mask_i;
    end
  end

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (vld_q[i] && waddr_q[i] == lookup_waddr_i) hit_o = 1'b1;
    end
  end

  assign empty_o      = (count_q == '0);
  assign head_waddr_o = waddr_q[head_q];
  assign head_data_o  = data_q[head_q];
  assign head_mask_o  = mask_q[head_q];

endmodule

// File: rtl/lsu_mem_wb_stage.sv
// Memory/writeback stage: single-port data memory behind a store buffer,
// sized/signed load formatting and a one-cycle registered writeback triple.
module lsu_mem_wb_stage
  import lsu_mem_wb_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int MEM_DEPTH   = 256,
  parameter int SB_DEPTH    = 4
) (
  input logic                 ls_clk,
  input logic                 ls_rst,
  lsu_mem_wb_stage_if.slave   ls_if
);

  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam int WAW  = DWIDTH - 2;

  logic              is_load, is_store, is_mem, sb_hit, sb_empty;
  logic              stall, accept, mis, load_rd, enq, deq;
  logic              rd_we_d, mis_d;
  acc_size_e         sz;
  logic [1:0]        off;
  logic [WAW-1:0]    waddr, head_waddr;
  logic [DWIDTH-1:0] st_data, head_data;
  logic [3:0]        st_mask, head_mask;
  logic              unused_head_bits;

  logic [DWIDTH-1:0]      mem [MEM_DEPTH];
  logic [DWIDTH-1:0]      rdata_q;
  logic                   valid_q, rd_we_q, mis_q, is_load_q;
  logic [AWIDTH-1:0]      rd_addr_q;
  logic [FUNCT_WIDTH-1:0] f3_q;
  logic [1:0]             off_q;
  logic [DWIDTH-1:0]      alu_q;

  function automatic logic [31:0] format_load(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[8*lane +: 8];
    h = w[16*lane[1] +: 16];
    case (f3)
      F3_LB:   r = b;
      F3_LH:   r = h;
      F3_LBU:  r = {24'b0, b};
      F3_LHU:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign is_load  = (ls_if.ls_i_opcode == OP_LOAD);
  assign is_store = (ls_if.ls_i_opcode == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign off      = ls_if.ls_i_alu_value[1:0];
  assign waddr    = ls_if.ls_i_alu_value[DWIDTH-1:2];
  assign sz       = decode_size(3'(ls_if.ls_i_funct3), is_load);
  assign mis      = is_mem & is_misaligned(sz, off);

  // A load that hits a buffered store waits until that store reaches memory.
  assign stall   = ls_if.ls_i_stall | (ls_if.ls_i_valid & is_load & sb_hit);
  assign accept  = ls_if.ls_i_valid & ~stall & ~ls_if.ls_i_flush;
  assign load_rd = accept & is_load & ~mis;
  assign enq     = accept & is_store & ~mis;
  assign deq     = ~sb_empty & ~load_rd & ~ls_rst;
  assign rd_we_d = accept & ~mis & ~is_store & ls_if.ls_i_rd_we;
  assign mis_d   = accept & mis;

  assign st_mask = byte_mask(sz, off);
  always_comb begin
    case (sz)
      SZ_BYTE: st_data = {4{ls_if.ls_i_rs2_data[7:0]}};
      SZ_HALF: st_data = {2{ls_if.ls_i_rs2_data[15:0]}};
      default: st_data = ls_if.ls_i_rs2_data;
    endcase
  end

  lsu_store_buffer #(
    .SB_DEPTH (SB_DEPTH),
    .WAW      (WAW),
    .DWIDTH   (DWIDTH)
  ) u_sb (
    .clk            (ls_clk),
    .rst            (ls_rst),
    .enq_i          (enq),
    .enq_waddr_i    (waddr),
    .enq_data_i     (st_data),
    .enq_mask_i     (st_mask),
    .deq_i          (deq),
    .lookup_waddr_i (waddr),
    .hit_o          (sb_hit),
    .empty_o        (sb_empty),
    .head_waddr_o   (head_waddr),
    .head_data_o    (head_data),
    .head_mask_o    (head_mask)
  );

  assign unused_head_bits = ^head_waddr[WAW-1:IDXW];

  // Single memory port: an accepted load owns it, otherwise the buffer head drains.
  always_ff @(posedge ls_clk) begin
    if (deq) begin
      for (int b = 0; b < 4; b++) begin
        if (head_mask[b]) mem[head_waddr[IDXW-1:0]][8*b +: 8] <= head_data[8*b +: 8];
      end
    end
    if (load_rd) rdata_q <= mem[ls_if.ls_i_alu_value[2 +: IDXW]];
  end

  always_ff @(posedge ls_clk) begin
    if (ls_rst) begin
      valid_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_we_q   <= 1'b0;
      mis_q     <= 1'b0;
      is_load_q <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      alu_q     <= '0;
    end else if (!ls_if.ls_i_stall) begin
      valid_q   <= accept;
      rd_addr_q <= ls_if.ls_i_rd_addr;
      rd_we_q   <= rd_we_d;
      mis_q     <= mis_d;
      is_load_q <= is_load;
      f3_q      <= ls_if.ls_i_funct3;
      off_q     <= off;
      alu_q     <= ls_if.ls_i_alu_value;
    end
  end

  assign ls_if.ls_o_stall      = stall;
  assign ls_if.ls_o_valid      = valid_q;
  assign ls_if.ls_o_rd_addr    = rd_addr_q;
  assign ls_if.ls_o_rd_data    = is_load_q ? format_load(rdata_q, off_q, 3'(f3_q)) : alu_q;
  assign ls_if.ls_o_rd_we      = rd_we_q;
  assign ls_if.ls_o_misaligned = mis_q;
  assign ls_if.ls_o_sb_empty   = sb_empty;

endmodule

// File: tb/tb_lsu_mem_wb_stage.sv
// Scoreboard bench for lsu_mem_wb_stage: a byte-array memory model predicts each
// writeback; a monitor compares the DUT output on every new valid cycle.
module tb_lsu_mem_wb_stage;
  import lsu_mem_wb_stage_pkg::*;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_wb_stage_if #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3)) bus ();

  lsu_mem_wb_stage #(
    .DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .MEM_DEPTH(256), .SB_DEPTH(4)
  ) dut (
    .ls_clk (clk),
    .ls_rst (rst),
    .ls_if  (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        mis;
    logic        chk_data;
    int          cyc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] mem_b [0:1023];
  bit         known [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h want=%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int access_bytes(input logic [6:0] op, input logic [2:0] f3);
    if (f3 == 3'd0 || (op == OP_LOAD && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (op == OP_LOAD && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    int v;
    case (f3)
      3'd0: begin v = int'(mem_b[a]); if (v >= 128) v -= 256; end
      3'd4: v = int'(mem_b[a]);
      3'd1: begin v = int'(mem_b[a]) + 256 * int'(mem_b[a+1]); if (v >= 32768) v -= 65536; end
      3'd5: v = int'(mem_b[a]) + 256 * int'(mem_b[a+1]);
      default: v = int'({mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]});
    endcase
    return 32'(v);
  endfunction

  task automatic model_accept(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [4:0] rd, input logic we);
    exp_t e;
    int   n;
    int   a;
    e.rd = rd; e.cyc = cyc + 1; e.chk_data = 1'b0; e.mis = 1'b0; e.we = 1'b0; e.data = '0;
    if (op == OP_LOAD || op == OP_STORE) begin
      n = access_bytes(op, f3);
      a = int'(addr);
      if (a % n != 0) e.mis = 1'b1;
      else if (op == OP_STORE) begin
        for (int i = 0; i < n; i++) mem_b[a+i] = data[8*i +: 8];
        if (n == 4) known[a/4] = 1'b1;
      end else begin
        e.we = we;
        e.chk_data = known[a/4];
        e.data = model_load(f3, a);
      end
    end else begin
      e.we = we; e.data = addr; e.chk_data = 1'b1;
    end
    q.push_back(e);
  endtask

  task automatic idle(input bit stall_in);
    @(negedge clk);
    bus.ls_i_valid = 1'b0;
    bus.ls_i_flush = 1'b0;
    bus.ls_i_stall = stall_in;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input logic we,
                       input bit flush, input bit allow_stall, output bit accepted, output bit saw_stall);
    int tries = 0;
    accepted = 1'b0;
    saw_stall = 1'b0;
    forever begin
      @(negedge clk);
      bus.ls_i_valid     = 1'b1;
      bus.ls_i_opcode    = op;
      bus.ls_i_funct3    = f3;
      bus.ls_i_alu_value = addr;
      bus.ls_i_rs2_data  = data;
      bus.ls_i_rd_addr   = rd;
      bus.ls_i_rd_we     = we;
      bus.ls_i_flush     = flush;
      bus.ls_i_stall     = allow_stall && !flush && ($urandom_range(0, 9) == 0);
      #1;
      if (flush) break;
      if (!bus.ls_o_stall) begin
        accepted = 1'b1;
        model_accept(op, f3, addr, data, rd, we);
        break;
      end
      saw_stall = 1'b1;
      tries++;
      if (tries > 50) begin
        chk("issue_stall_timeout", 32'(tries), 32'd50);
        break;
      end
    end
  endtask

  // Monitor: a fresh output appears on every edge not held by downstream stall.
  initial begin : monitor
    logic        stall_e, rst_e;
    logic        s_v, s_we, s_mis;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    exp_t        e;
    s_v = 0; s_we = 0; s_mis = 0; s_rd = 0; s_data = 0;
    forever begin
      @(posedge clk);
      stall_e = bus.ls_i_stall;
      rst_e   = rst;
      #1;
      if (!rst_e) begin
        if (stall_e) begin
          chk("hold_valid", 32'(bus.ls_o_valid), 32'(s_v));
          chk("hold_data", bus.ls_o_rd_data, s_data);
          chk("hold_ctrl", {bus.ls_o_rd_addr, bus.ls_o_rd_we, bus.ls_o_misaligned},
              {s_rd, s_we, s_mis});
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("wb_latency", 32'(cyc), 32'(e.cyc));
          chk("wb_valid", 32'(bus.ls_o_valid), 32'd1);
          chk("wb_rd_addr", 32'(bus.ls_o_rd_addr), 32'(e.rd));
          chk("wb_rd_we", 32'(bus.ls_o_rd_we), 32'(e.we));
          chk("wb_misaligned", 32'(bus.ls_o_misaligned), 32'(e.mis));
          if (e.chk_data) chk("wb_rd_data", bus.ls_o_rd_data, e.data);
        end else begin
          chk("idle_valid", 32'(bus.ls_o_valid), 32'd0);
        end
      end
      s_v = bus.ls_o_valid; s_we = bus.ls_o_rd_we; s_mis = bus.ls_o_misaligned;
      s_rd = bus.ls_o_rd_addr; s_data = bus.ls_o_rd_data;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit acc, st;
    logic [6:0] op;
    int kind;
    bus.ls_i_valid = 0; bus.ls_i_opcode = 0; bus.ls_i_funct3 = 0; bus.ls_i_alu_value = 0;
    bus.ls_i_rs2_data = 0; bus.ls_i_rd_addr = 0; bus.ls_i_rd_we = 0;
    bus.ls_i_stall = 0; bus.ls_i_flush = 0;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(bus.ls_o_valid), 32'd0);
    chk("reset_rd_data", bus.ls_o_rd_data, 32'd0);
    chk("reset_ctrl", {bus.ls_o_rd_addr, bus.ls_o_rd_we, bus.ls_o_misaligned, bus.ls_o_stall}, '0);
    chk("reset_sb_empty", 32'(bus.ls_o_sb_empty), 32'd1);
    rst = 1'b0;

    for (int w = 0; w < 64; w++) issue(OP_STORE, F3_SW, 32'(w * 4), $urandom, 5'(w), 1'b1, 0, 0, acc, st);
    repeat (3) idle(0);

    // Store then load of the same word.
    issue(OP_STORE, F3_SW, 32'h10, 32'hDEADBEEF, 5'd1, 1'b1, 0, 0, acc, st);
    idle(0);
    issue(OP_LOAD, F3_LW, 32'h10, 32'h0, 5'd5, 1'b1, 0, 0, acc, st);

    // Byte store forwarded by stalling the dependent load until it drains.
    issue(OP_STORE, F3_SB, 32'h21, 32'h80, 5'd2, 1'b1, 0, 0, acc, st);
    issue(OP_LOAD, F3_LB, 32'h21, 32'h0, 5'd6, 1'b1, 0, 0, acc, st);
    chk("raw_stall_seen", 32'(st), 32'd1);
    chk("raw_load_accepted", 32'(acc), 32'd1);
    issue(OP_LOAD, F3_LBU, 32'h21, 32'h0, 5'd7, 1'b1, 0, 0, acc, st);

    // Back-to-back stores never stall.
    for (int k = 0; k < 5; k++) begin
      issue(OP_STORE, F3_SW, 32'(8'h80 + 4 * k), $urandom, 5'd3, 1'b1, 0, 0, acc, st);
      chk("store_no_stall", 32'(st), 32'd0);
    end
    repeat (4) idle(0);
    #1 chk("sb_empty_after_drain", 32'(bus.ls_o_sb_empty), 32'd1);

    // Misaligned accesses.
    issue(OP_LOAD, F3_LH, 32'h03, 32'h0, 5'd8, 1'b1, 0, 0, acc, st);
    issue(OP_STORE, F3_SW, 32'h02, 32'hCAFEF00D, 5'd9, 1'b1, 0, 0, acc, st);
    issue(OP_LOAD, F3_LW, 32'h00, 32'h0, 5'd10, 1'b1, 0, 0, acc, st);
    repeat (3) idle(0);

    // Flushed store.
    issue(OP_STORE, F3_SW, 32'h40, 32'h12345678, 5'd11, 1'b1, 1, 0, acc, st);
    chk("flush_not_accepted", 32'(acc), 32'd0);
    idle(0);
    #1 chk("flush_sb_empty", 32'(bus.ls_o_sb_empty), 32'd1);
    issue(OP_LOAD, F3_LW, 32'h40, 32'h0, 5'd12, 1'b1, 0, 0, acc, st);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) idle($urandom_range(0, 2) == 0);
      else begin
        op = (kind < 5) ? OP_LOAD : (kind < 8) ? OP_STORE : (kind == 8) ? OP_ADD : OP_ADDI;
        issue(op, 3'($urandom_range(0, 7)),
              (op == OP_LOAD || op == OP_STORE) ? 32'($urandom_range(0, 255)) : $urandom,
              $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 9) == 0, 1, acc, st);
      end
    end
    repeat (6) idle(0);

    // Reset discards buffered stores; a pass-through op works right after.
    issue(OP_STORE, F3_SW, 32'h300, 32'h11111111, 5'd13, 1'b1, 0, 0, acc, st);
    issue(OP_STORE, F3_SW, 32'h304, 32'h22222222, 5'd14, 1'b1, 0, 0, acc, st);
    @(negedge clk);
    chk("sb_busy_before_reset", 32'(bus.ls_o_sb_empty), 32'd0);
    bus.ls_i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    known[192] = 1'b0;
    known[193] = 1'b0;
    chk("reset_sb_empty2", 32'(bus.ls_o_sb_empty), 32'd1);
    chk("reset_valid2", 32'(bus.ls_o_valid), 32'd0);
    rst = 1'b0;
    issue(OP_ADD, 3'd0, 32'h5, 32'h0, 5'd15, 1'b1, 0, 0, acc, st);
    repeat (3) idle(0);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
